// File: rtl/soc_sweep_scheduler_if.sv
// soc_sweep_scheduler_if: control/status and RAM-write bundle of the aging-monitor sweep scheduler
// master drives start_i, continuous_i, ch_mask_i, window_i; slave (the scheduler) drives
// osc_sel_o, osc_resetn_o, mem_addr_o, mem_wr_n_o, busy_o, done_o, sweep_cnt_o
interface soc_sweep_scheduler_if #(
  parameter int NUM_CH = 5,
  parameter int ADDR_W = 5,
  parameter int WIN_W  = 16
);
  logic              start_i;
  logic              continuous_i;
  logic [NUM_CH-1:0] ch_mask_i;
  logic [WIN_W-1:0]  window_i;
  logic [ADDR_W-1:0] osc_sel_o;
  logic              osc_resetn_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_wr_n_o;
  logic              busy_o;
  logic              done_o;
  logic [15:0]       sweep_cnt_o;
  modport master (
    output start_i, continuous_i, ch_mask_i, window_i,
    input  osc_sel_o, osc_resetn_o, mem_addr_o, mem_wr_n_o, busy_o, done_o, sweep_cnt_o
  );
  modport slave (
    input  start_i, continuous_i, ch_mask_i, window_i,
    output osc_sel_o, osc_resetn_o, mem_addr_o, mem_wr_n_o, busy_o, done_o, sweep_cnt_o
  );
endinterface

// File: rtl/soc_sweep_scheduler.sv
// soc_sweep_scheduler: maskable, optionally continuous per-channel measurement sequencer for spcounters
// clk/rst: clock and synchronous active-high reset; s: slave side of soc_sweep_scheduler_if
// (start/continuous/mask/window in; osc select, counter reset, RAM write strobe, busy/done, sweep count out)
module soc_sweep_scheduler #(
  parameter int NUM_CH     = 5,
  parameter int ADDR_W     = 5,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input logic                  clk,
  input logic                  rst,
  soc_sweep_scheduler_if.slave s
);
  typedef enum logic [2:0] {IDLE, SCAN, RST, SETTLE, MEAS, HOLD, WRITE, END_S} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CH - 1);
  state_t            r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [WIN_W-1:0]  r_win;
  logic [WIN_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_sel;
  logic              r_resetn;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_n;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_sweep;
  logic              w_en;
  logic              w_last;
  logic [ADDR_W-1:0] w_nxt;
  logic [WIN_W-1:0]  w_meas;
  // shift-and-mask avoids indexing the NUM_CH-wide mask with a wider pointer
  assign w_en   = |(r_mask & (NUM_CH'(1) << r_ptr));
  assign w_last = r_ptr == LAST;
  assign w_nxt  = r_ptr + ADDR_W'(1);
  // r_cnt counts down to 0, so load length-1; a zero window still measures one cycle
  assign w_meas = (r_win == '0) ? '0 : r_win - WIN_W'(1);
  assign s.osc_sel_o    = r_sel;
  assign s.osc_resetn_o = r_resetn;
  assign s.mem_addr_o   = r_addr;
  assign s.mem_wr_n_o   = r_wr_n;
  assign s.busy_o       = r_busy;
  assign s.done_o       = r_done;
  assign s.sweep_cnt_o  = r_sweep;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_resetn <= 1'b0;
      r_addr   <= '0;
      r_wr_n   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sweep  <= '0;
    end else begin
      r_done <= 1'b0;
      r_wr_n <= 1'b1;
      case (r_state)
        IDLE: if (s.start_i) begin
          r_mask  <= s.ch_mask_i;
          r_win   <= s.window_i;
          r_ptr   <= '0;
          r_sel   <= '0;
          r_busy  <= 1'b1;
          r_state <= SCAN;
        end
        SCAN: if (w_en) begin
          r_cnt   <= WIN_W'(1);
          r_state <= RST;
        end else if (w_last) begin
          r_state <= END_S;
        end else begin
          r_ptr <= w_nxt;
          r_sel <= w_nxt;
        end
        RST: if (r_cnt == '0) begin
          r_cnt    <= WIN_W'(SETTLE_CYC - 1);
          r_resetn <= 1'b1;
          r_state  <= SETTLE;
        end else r_cnt <= r_cnt - WIN_W'(1);
        SETTLE: if (r_cnt == '0) begin
          r_cnt   <= w_meas;
          r_state <= MEAS;
        end else r_cnt <= r_cnt - WIN_W'(1);
        MEAS: if (r_cnt == '0) begin
          r_cnt   <= WIN_W'(1);
          r_state <= HOLD;
        end else r_cnt <= r_cnt - WIN_W'(1);
        // counter stays out of reset so the two-stage capture sees a stable value
        HOLD: if (r_cnt == '0) begin
          r_wr_n  <= 1'b0;
          r_addr  <= r_ptr;
          r_state <= WRITE;
        end else r_cnt <= r_cnt - WIN_W'(1);
        WRITE: begin
          r_resetn <= 1'b0;
          if (w_last) r_state <= END_S;
          else begin
            r_ptr   <= w_nxt;
            r_sel   <= w_nxt;
            r_state <= SCAN;
          end
        end
        END_S: begin
          r_sweep <= r_sweep + 16'd1;
          if (s.continuous_i) begin
            r_mask  <= s.ch_mask_i;
            r_win   <= s.window_i;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_state <= SCAN;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_sweep_scheduler.sv
// tb_soc_sweep_scheduler: scoreboard bench for soc_sweep_scheduler (write strobes and done pulses timed to the cycle)
module tb_soc_sweep_scheduler;
  localparam int SETTLE = 4;
  typedef struct {bit dn; logic [4:0] a; int c;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  q[$];
  ev_t  me;
  soc_sweep_scheduler_if #(.NUM_CH(5), .ADDR_W(5), .WIN_W(16)) s ();
  soc_sweep_scheduler #(.NUM_CH(5), .ADDR_W(5), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk),
    .rst(rst),
    .s(s)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic chk_reset();
    chk("rst_sel", s.osc_sel_o, 0);
    chk("rst_resetn", s.osc_resetn_o, 0);
    chk("rst_addr", s.mem_addr_o, 0);
    chk("rst_wr_n", s.mem_wr_n_o, 1);
    chk("rst_busy", s.busy_o, 0);
    chk("rst_done", s.done_o, 0);
    chk("rst_sweep", s.sweep_cnt_o, 0);
  endtask
  // model of one sweep starting in SCAN at cycle c0; returns first cycle after END
  task automatic push_sweep(input int c0, input logic [4:0] m, input int w, input bit fin, output int nxt);
    int t = c0;
    int wm = (w == 0) ? 1 : w;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        q.push_back('{1'b0, 5'(i), t + 5 + SETTLE + wm});
        t += 6 + SETTLE + wm;
      end else t++;
    end
    if (fin) q.push_back('{1'b1, 5'd0, t + 1});
    nxt = t + 1;
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (s.busy_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", s.busy_o, 0);
    @(negedge clk);
  endtask
  // drives start at a negedge; returns the cycle the DUT is first seen in SCAN
  task automatic go(input logic [4:0] m, input logic [15:0] w, output int c0);
    s.ch_mask_i = m;
    s.window_i  = w;
    s.start_i   = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    s.start_i = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!s.mem_wr_n_o || s.done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_wr_n", s.mem_wr_n_o, 1);
        chk("unexpected_done", s.done_o, 0);
      end else begin
        me = q.pop_front();
        chk("ev_done", s.done_o, me.dn);
        chk("ev_cyc", cyc, me.c);
        if (!me.dn) begin
          chk("wr_addr", s.mem_addr_o, me.a);
          chk("wr_sel", s.osc_sel_o, me.a);
        end
      end
    end
  end
  initial begin
    int c0, n1, n2, n3;
    s.start_i = 1'b0;
    s.continuous_i = 1'b0;
    s.ch_mask_i = '0;
    s.window_i = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    // single channel, window 10; start while busy must be ignored
    go(5'b00001, 16'd10, c0);
    push_sweep(c0, 5'b00001, 10, 1, n1);
    chk("busy_rise", s.busy_o, 1);
    wait_cyc(c0 + 1);
    chk("resetn_rst0", s.osc_resetn_o, 0);
    wait_cyc(c0 + 2);
    chk("resetn_rst1", s.osc_resetn_o, 0);
    wait_cyc(c0 + 3);
    chk("resetn_settle", s.osc_resetn_o, 1);
    s.start_i = 1'b1;
    @(negedge clk);
    s.start_i = 1'b0;
    wait_idle();
    chk("sweep_t1", s.sweep_cnt_o, 1);
    chk("q_t1", q.size(), 0);
    // sparse mask
    go(5'b10101, 16'd3, c0);
    push_sweep(c0, 5'b10101, 3, 1, n1);
    wait_idle();
    chk("sweep_t2", s.sweep_cnt_o, 2);
    chk("q_t2", q.size(), 0);
    // empty mask
    go(5'b00000, 16'd7, c0);
    push_sweep(c0, 5'b00000, 7, 1, n1);
    wait_idle();
    chk("sweep_t3", s.sweep_cnt_o, 3);
    chk("q_t3", q.size(), 0);
    // continuous, dropped during the third sweep
    s.continuous_i = 1'b1;
    go(5'b00011, 16'd2, c0);
    push_sweep(c0, 5'b00011, 2, 0, n1);
    push_sweep(n1, 5'b00011, 2, 0, n2);
    push_sweep(n2, 5'b00011, 2, 1, n3);
    wait_cyc(n1);
    chk("sweep_cont1", s.sweep_cnt_o, 4);
    chk("busy_cont", s.busy_o, 1);
    wait_cyc(n2 + 3);
    chk("sweep_cont2", s.sweep_cnt_o, 5);
    s.continuous_i = 1'b0;
    wait_idle();
    chk("sweep_t4", s.sweep_cnt_o, 6);
    chk("q_t4", q.size(), 0);
    // zero window and sweep counter wrap
    force dut.r_sweep = 16'hFFFF;
    @(negedge clk);
    release dut.r_sweep;
    @(negedge clk);
    chk("sweep_pre", s.sweep_cnt_o, 16'hFFFF);
    go(5'b00001, 16'd0, c0);
    push_sweep(c0, 5'b00001, 0, 1, n1);
    wait_idle();
    chk("sweep_wrap", s.sweep_cnt_o, 0);
    chk("q_t5", q.size(), 0);
    // reset during MEAS of channel 2
    go(5'b00100, 16'd20, c0);
    wait_cyc(c0 + 12);
    chk("pre_rst_sel", s.osc_sel_o, 2);
    chk("pre_rst_resetn", s.osc_resetn_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_busy", s.busy_o, 0);
    go(5'b00001, 16'd1, c0);
    push_sweep(c0, 5'b00001, 1, 1, n1);
    chk("restart_sel", s.osc_sel_o, 0);
    wait_idle();
    chk("sweep_t6", s.sweep_cnt_o, 1);
    chk("q_t6", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/soc_sweep_scheduler.md
Name: soc_sweep_scheduler

Overview:
Sequences the aging-monitor measurement loop for a region of NUM_CH spcounter channels. For each enabled channel it selects the oscillator, pulses its counter reset, waits a settle time, and counts for a programmed window. It then waits out the two-stage data-capture pipeline and issues a single-cycle write strobe into the result RAM. It replaces the free-running counter control with a start/busy/done-controlled, maskable, optionally continuous sweep.

Parameters:
NUM_CH, 5, number of monitored channels (1..2**ADDR_W).
ADDR_W, 5, channel select / RAM write-address width.
WIN_W, 16, measurement-window counter width.
SETTLE_CYC, 4, cycles between counter-reset release and window start (>=1).

Ports:
clk  in  1  sample-domain clock; everything is synchronous to it.
rst  in  1  synchronous reset, active-high.
start_i  in  1  begin a sweep; sampled only in IDLE.
continuous_i  in  1  sampled at the end of each sweep; 1 = start the next sweep immediately.
ch_mask_i  in  NUM_CH  channel enable bits; 1 = measure; latched at start.
window_i  in  WIN_W  measurement window length in cycles; latched at start; 0 is treated as 1.
osc_sel_o  out  ADDR_W  currently selected channel.
osc_resetn_o  out  1  active-low counter reset to the spcounter.
mem_addr_o  out  ADDR_W  RAM write address.
mem_wr_n_o  out  1  RAM write strobe, active-low, one cycle per measured channel.
busy_o  out  1  high in every state except IDLE.
done_o  out  1  one-cycle pulse when a non-continuous sweep ends.
sweep_cnt_o  out  16  completed-sweep counter; wraps 0xFFFF->0.

Behaviour:
- Reset values (the rst edge wins over all other inputs):
  - state=IDLE, osc_sel_o=0, osc_resetn_o=0, mem_addr_o=0, mem_wr_n_o=1, busy_o=0, done_o=0, sweep_cnt_o=0, channel pointer=0.
- Reset mid-sweep aborts at the next edge with no write strobe.
- All outputs are registered.
- States:
  - IDLE: osc_resetn_o=0. If start_i=1: latch mask and window, set ptr=0, go to SCAN.
  - SCAN (1 cycle per channel): osc_sel_o=ptr.
    - If mask[ptr]=1: go to RST.
    - Else if ptr=NUM_CH-1: go to END.
    - Else ptr+1 and stay in SCAN.
  - RST (2 cycles): osc_resetn_o=0, then go to SETTLE.
  - SETTLE (SETTLE_CYC cycles): osc_resetn_o=1, counter not yet counted; then go to MEAS.
  - MEAS (max(window,1) cycles): osc_resetn_o=1; then go to HOLD.
  - HOLD (2 cycles): covers the two-register capture pipeline; osc_resetn_o stays 1 so the counter value stays stable.
  - WRITE (1 cycle): mem_wr_n_o=0, mem_addr_o=ptr.
    - If ptr=NUM_CH-1: go to END.
    - Else ptr+1 and go to SCAN.
  - END (1 cycle): sweep_cnt_o+1.
    - If continuous_i=1: relatch mask and window, ptr=0, go to SCAN.
    - Else done_o=1, go to IDLE.
- Per enabled channel: 1+2+SETTLE_CYC+W+2+1 cycles. A masked channel costs 1 cycle.
- start_i while busy is ignored. Clearing continuous_i mid-sweep lets the current sweep finish, then assert done_o.
- Mask all zero: NUM_CH SCAN cycles, then END, done_o; no write strobes.
- osc_sel_o is stable from SCAN through WRITE for each channel.
- mem_addr_o holds its last value outside WRITE.
- Channel pointer never exceeds NUM_CH-1.
- A single window counter of width WIN_W is reused for the RST, SETTLE and HOLD counts.

Test Plan:
- Defaults; mask=5'b00001, window=10; start at edge 0:
  - busy_o rises at edge 1.
  - osc_resetn_o=0 for 2 cycles, then 1.
  - mem_wr_n_o=0 for exactly one cycle with mem_addr_o=0, 20 cycles after SCAN entry (1+2+4+10+2+1).
  - No further channels are measured; done_o pulses; sweep_cnt_o=1.
- mask=5'b10101, window=3: exactly three write strobes at addresses 0, 2, 4 in that order; masked channels cost 1 cycle each; done_o pulses once; sweep_cnt_o=1.
- mask=0: done_o pulses NUM_CH+2 cycles after start; mem_wr_n_o stays 1 throughout.
- continuous_i=1, mask=5'b00011: write strobes cycle through addresses 0,1,0,1,...; sweep_cnt_o increments each sweep and done_o stays 0. Drop continuous_i mid-sweep: that sweep completes, then done_o pulses and the block returns to IDLE.
- window=0: MEAS lasts 1 cycle. Preload sweep_cnt_o to 0xFFFF (force) and complete a sweep: it wraps to 0.
- rst asserted during MEAS of channel 2: the next edge restores every reset value; no write strobe occurs; a fresh start then begins again at channel 0.
